relu_drain_ctrl: RTL

Sequences the drain of a finished tile from the output buffer through the relu stage and on to the writeback port. On a start pulse it reads a configured number of rows and drives relu_en for the whole tile. It tracks the fixed buffer-read and relu latencies with a valid shift pipeline, then captures relu results in a small skid FIFO. Rows are emitted on a valid/ready write port with addresses. It sits between the output buffer, the relu array and the writeback/DMA path.

---
 rtl/relu_drain_ctrl_pkg.sv | 25 ++
 rtl/relu_skid_fifo.sv | 53 +++++
 rtl/relu_drain_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/relu_drain_ctrl_pkg.sv
// Shared sizing and state encoding for the relu drain controller and its skid FIFO.
// DW falls back to the array defaults when the project config macros are not defined.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 8
`endif

package relu_drain_ctrl_pkg;

    localparam int DW = `ARRAYWIDTH * `OUTPUT_BUF_DATASIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/relu_skid_fifo.sv
// Skid FIFO that catches relu results still in flight when the writeback sink stalls.
// The head reads as zero while empty so an idle write port shows no stale data.
module relu_skid_fifo
    import relu_drain_ctrl_pkg::*;
#(
    parameter int  WIDTH = DW,
    parameter int  DEPTH = 4,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    // Credit on the read side must make this unreachable.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: rtl/relu_drain_ctrl.sv
// Drains one tile from the output buffer through the relu array to the writeback port.
//
// state  | meaning
// IDLE   | waiting for start, all strobes low
// ISSUE  | issuing buffer reads while FIFO credit remains
// DRAIN  | all reads issued, waiting for the last write to be accepted
// DONE   | one-cycle done pulse, then back to IDLE
module relu_drain_ctrl
    import relu_drain_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int ROW_W      = 16,
    parameter int RD_LAT     = 1,
    parameter int RELU_LAT   = 1,
    parameter int FIFO_DEPTH = RD_LAT + RELU_LAT + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              cfg_relu_en,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              relu_en,
    input  logic [DW-1:0]     relu_out,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    input  logic              wr_ready
);

    localparam int PIPE_LEN = RD_LAT + RELU_LAT;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);

    drain_state_t      state, state_nxt;
    logic [ROW_W-1:0]  rows_q, issued, written;
    logic [ADDR_W-1:0] rd_base_q, wr_base_q;
    logic              relu_en_q;
    logic [PIPE_LEN-1:0] vpipe;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              rd_fire, pop, accept, credit_ok;
    int unsigned       inflight;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < PIPE_LEN; i++) inflight = inflight + 32'(vpipe[i]);
    end

    assign credit_ok = (inflight + 32'(fifo_count)) < 32'(FIFO_DEPTH);
    assign pop       = !fifo_empty && wr_ready;
    assign accept    = (state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = (cfg_rows == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    rd_fire = 1'b1;
                    if (issued + ROW_W'(1) == rows_q) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle of the final pop so done follows it directly.
                if (written == rows_q || (pop && written + ROW_W'(1) == rows_q))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q    <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            relu_en_q <= 1'b0;
            issued    <= '0;
            written   <= '0;
            vpipe     <= '0;
        end else begin
            if (accept) begin
                rows_q    <= cfg_rows;
                rd_base_q <= cfg_rd_base;
                wr_base_q <= cfg_wr_base;
                relu_en_q <= cfg_relu_en;
                issued    <= '0;
                written   <= '0;
            end else begin
                if (rd_fire) issued <= issued + ROW_W'(1);
                if (pop)     written <= written + ROW_W'(1);
                if (state == ST_DONE) relu_en_q <= 1'b0;
            end
            vpipe[0] <= rd_fire;
            for (int i = 1; i < PIPE_LEN; i++) vpipe[i] <= vpipe[i-1];
        end
    end

    relu_skid_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vpipe[PIPE_LEN-1]),
        .push_data (relu_out),
        .pop       (pop),
        .head      (wr_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign buf_rd_en   = rd_fire;
    assign buf_rd_addr = rd_base_q + ADDR_W'(issued);
    assign relu_en     = relu_en_q;
    assign wr_valid    = !fifo_empty;
    assign wr_addr     = wr_base_q + ADDR_W'(written);

endmodule
